// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: fixed-latency store reads behind a
// credit-limited first-word-fall-through response FIFO.
module imem_fetch_responder #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int LATENCY         = 2,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    req_addr,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_instr,
  output logic [31:0]                    resp_addr,
  output logic                           resp_err,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
  input  logic [31:0]                    load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (RESP_FIFO_DEPTH > 1) ?
                      $clog2(RESP_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(RESP_FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  logic [31:0]   mem [DEPTH_WORDS];
  rsp_t          fifo [RESP_FIFO_DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] fcnt;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          accept;
  logic          pop;
  logic          push;
  logic          err0;
  rsp_t          s0;
  rsp_t          push_d;
  rsp_t          head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RESP_FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // credits are taken at accept, so the FIFO always has room on push
  assign req_ready  = count < CW'(RESP_FIFO_DEPTH);
  assign accept     = req_valid && req_ready;
  assign resp_valid = fcnt != '0;
  assign pop        = resp_valid && resp_ready;

  assign err0 = (req_addr[1:0] != 2'b00) ||
                (req_addr[31:2] >= 30'(DEPTH_WORDS));

  always_comb begin
    s0       = '0;
    s0.addr  = req_addr;
    s0.err   = err0;
    s0.instr = err0 ? NOP : mem[req_addr[AW+1:2]];
  end

  // old data wins on a same-edge load/read collision
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  generate
    if (LATENCY == 1) begin : g_l1
      assign push   = accept;
      assign push_d = s0;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv;
      rsp_t               pd [LATENCY-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pv <= '0;
          for (int i = 0; i < LATENCY - 1; i++) pd[i] <= '0;
        end else begin
          pv[0] <= accept;
          pd[0] <= s0;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push   = pv[LATENCY-2];
      assign push_d = pd[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= push_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      fcnt  <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      fcnt  <= fcnt + CW'(push) - CW'(pop);
      count <= count + CW'(accept) - CW'(pop);
    end
  end

  assign head       = fifo[rp];
  assign resp_instr = resp_valid ? head.instr : '0;
  assign resp_addr  = resp_valid ? head.addr  : '0;
  assign resp_err   = resp_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: a store model predicts each
// response when the request is accepted; responses are checked at pop.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          pops[$];
  logic [31:0] mdl [1024];
  int          nchk = 0;
  int          nerr = 0;
  int          npop = 0;
  int          cyc  = 0;

  imem_fetch_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    e.addr  = a;
    e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
    e.instr = e.err ? 32'h0000_0013 : mdl[a[11:2]];
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("instr", resp_instr, e.instr);
          chk("addr", resp_addr, e.addr);
          chk("err", {31'd0, resp_err}, {31'd0, e.err});
        end
        npop <= npop + 1;
        pops.push_back(cyc);
      end
      if (req_valid && req_ready) q.push_back(predict(req_addr));
      if (load_en) mdl[load_addr] <= load_data;
    end
  end

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk) #1;
    load_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a);
    int n = 0;
    req_valid = 1'b1;
    req_addr = a;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        chk("accept timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk) #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    chk("drain left", q.size(), 32'd0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel resp_err", {31'd0, resp_err}, 32'd0);
    chk("rel resp_instr", resp_instr, 32'd0);
    chk("rel resp_addr", resp_addr, 32'd0);
    @(posedge clk) #1;

    load(10'd3, 32'h0050_0093);
    send(32'h0000_000C);
    chk("lat early", {31'd0, resp_valid}, 32'd0);
    @(posedge clk) #1;
    chk("lat due", {31'd0, resp_valid}, 32'd1);
    drain();

    for (int i = 0; i < 4; i++) load(10'(i), 32'h11 * (i + 1));
    pops.delete();
    for (int i = 0; i < 4; i++) begin
      chk("stream ready", {31'd0, req_ready}, 32'd1);
      send(32'(i * 4));
    end
    drain();
    chk("stream pops", pops.size(), 32'd4);
    if (pops.size() == 4) chk("stream gap", pops[3] - pops[0], 32'd3);

    load(10'd4, 32'h0000_0055);
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i * 4));
    chk("full ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk) #1;
      chk("held", {31'd0, req_ready}, 32'd0);
      chk("held depth", q.size(), 32'd4);
    end
    resp_ready = 1'b1;
    @(posedge clk) #1;
    chk("ready after pop", {31'd0, req_ready}, 32'd1);
    @(posedge clk) #1;
    req_valid = 1'b0;
    drain();

    send(32'h0000_0002);
    send(32'h0000_1000);
    drain();

    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(i * 4));
    #2 reset = 1'b1;
    q.delete();
    #1;
    chk("mid rst valid", {31'd0, resp_valid}, 32'd0);
    chk("mid rst ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    begin
      int np;
      np = npop;
      resp_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("no stale", npop - np, 32'd0);
    end

    load(10'd5, 32'h0000_0505);
    load_en = 1'b1;
    load_addr = 10'd5;
    load_data = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    req_addr = 32'h14;
    @(posedge clk) #1;
    load_en = 1'b0;
    req_valid = 1'b0;
    chk("coll predict", q[0].instr, 32'h0000_0505);
    send(32'h14);
    drain();
    chk("coll total", mdl[5], 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
